// File: rtl/voodoo_pkg.sv
// voodoo_pkg: shared state encoding and frame-length helper for the purple/electric/haze link
// Contents:
//   state_t   - transmitter/receiver frame states
//   frame_len - haze-high cycles per frame for a given width, bit period and parity setting
package voodoo_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    function automatic int frame_len(input int width, input int clks_per_bit, input bit parity_en);
        return (2 + width + int'(parity_en)) * clks_per_bit;
    endfunction

endpackage

// File: rtl/voodoo_child_riff_tick.sv
// riff_tick: bit-period divider counting 0..CLKS_PER_BIT-1 while a frame is in flight
// Ports:
//   mclk, resetb - clock and asynchronous active-high reset
//   en           - a frame bit is being sent this cycle (divider counts)
//   clr          - no frame next cycle (divider returns to 0)
//   first        - registered: this cycle is the first of a bit period (electric source)
//   last         - this cycle is the last of a bit period (state advance)
//   last_next    - next cycle will be the last of a bit period
module riff_tick #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic mclk,
    input  logic resetb,
    input  logic en,
    input  logic clr,
    output logic first,
    output logic last,
    output logic last_next
);

    localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] TOP = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt, cnt_d;

    assign last      = en && cnt == TOP;
    assign cnt_d     = (!en || clr || last) ? '0 : cnt + CW'(1);
    assign last_next = !clr && cnt_d == TOP;

    always_ff @(posedge mclk or posedge resetb) begin
        if (resetb) begin
            cnt   <= '0;
            first <= 1'b0;
        end else begin
            cnt   <= cnt_d;
            first <= !clr && cnt_d == '0;
        end
    end

endmodule

// File: rtl/voodoo_child.sv
// voodoo_child: serial frame transmitter (start, LSB-first data, optional even parity, stop)
// Ports:
//   mclk, resetb - clock and asynchronous active-high reset
//   tx_data      - word to send, sampled only on handshake
//   tx_valid     - tx_data valid
//   tx_ready     - idle; word accepted when tx_valid & tx_ready at a rising edge
//   purple       - serial line, idles high
//   electric     - strobe on the first cycle of every bit period in a frame
//   haze         - frame envelope, start bit through stop bit
//   ladyland     - pulse on the last cycle of the stop bit
module voodoo_child
    import voodoo_pkg::*;
#(
    parameter int WIDTH        = 3,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic             mclk,
    input  logic             resetb,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             purple,
    output logic             electric,
    output logic             haze,
    output logic             ladyland
);

    localparam int IW = WIDTH > 1 ? $clog2(WIDTH) : 1;

    state_t           state, nxt;
    logic [WIDTH-1:0] sh, sh_d;
    logic [IW-1:0]    idx, idx_d;
    logic             par, par_d;
    logic             last, last_next;
    logic             purple_d;

    riff_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
        .mclk      (mclk),
        .resetb    (resetb),
        .en        (state != IDLE),
        .clr       (nxt == IDLE),
        .first     (electric),
        .last      (last),
        .last_next (last_next)
    );

    always_comb begin
        nxt   = state;
        sh_d  = sh;
        idx_d = idx;
        par_d = par;
        case (state)
            IDLE: if (tx_valid && tx_ready) begin
                nxt   = START;
                sh_d  = tx_data;
                par_d = ^tx_data;
            end
            START: if (last) begin
                nxt   = DATA;
                idx_d = '0;
            end
            DATA: if (last) begin
                sh_d  = sh >> 1;
                idx_d = idx + IW'(1);
                if (idx == IW'(WIDTH - 1))
                    nxt = (PARITY_EN != 0) ? PARITY : STOP;
            end
            PARITY: if (last) nxt = STOP;
            default: if (last) nxt = IDLE;
        endcase
        // outputs are registered from the next state so they line up with it
        purple_d = nxt == START  ? 1'b0 :
                   nxt == DATA   ? sh_d[0] :
                   nxt == PARITY ? par_d : 1'b1;
    end

    always_ff @(posedge mclk or posedge resetb) begin
        if (resetb) begin
            state    <= IDLE;
            sh       <= '0;
            idx      <= '0;
            par      <= 1'b0;
            tx_ready <= 1'b0;
            purple   <= 1'b1;
            haze     <= 1'b0;
            ladyland <= 1'b0;
        end else begin
            state    <= nxt;
            sh       <= sh_d;
            idx      <= idx_d;
            par      <= par_d;
            tx_ready <= nxt == IDLE;
            purple   <= purple_d;
            haze     <= nxt != IDLE;
            ladyland <= nxt == STOP && last_next;
        end
    end

endmodule

// File: tb/tb_voodoo_child.sv
// tb_voodoo_child: checks three voodoo_child configurations against a frame-position model
module tb_voodoo_child;

    localparam int N = 3;

    logic       mclk = 1'b0;
    logic       resetb = 1'b0;
    logic [2:0] tx_data [N];
    logic       tx_valid [N];
    logic       tx_ready [N];
    logic       purple [N];
    logic       electric [N];
    logic       haze [N];
    logic       ladyland [N];

    int checks = 0;
    int fails = 0;
    bit go = 0;

    int         pos [N];
    logic       mready [N];
    logic [2:0] word [N];

    always #5 mclk = ~mclk;

    voodoo_child #(.WIDTH(3), .CLKS_PER_BIT(4), .PARITY_EN(1)) dut0 (
        .mclk(mclk), .resetb(resetb), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
        .tx_ready(tx_ready[0]), .purple(purple[0]), .electric(electric[0]),
        .haze(haze[0]), .ladyland(ladyland[0]));

    voodoo_child #(.WIDTH(3), .CLKS_PER_BIT(4), .PARITY_EN(0)) dut1 (
        .mclk(mclk), .resetb(resetb), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
        .tx_ready(tx_ready[1]), .purple(purple[1]), .electric(electric[1]),
        .haze(haze[1]), .ladyland(ladyland[1]));

    voodoo_child #(.WIDTH(3), .CLKS_PER_BIT(1), .PARITY_EN(1)) dut2 (
        .mclk(mclk), .resetb(resetb), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
        .tx_ready(tx_ready[2]), .purple(purple[2]), .electric(electric[2]),
        .haze(haze[2]), .ladyland(ladyland[2]));

    function automatic int cpb(input int i);
        return i == 2 ? 1 : 4;
    endfunction

    function automatic bit pen(input int i);
        return i != 1;
    endfunction

    function automatic int flen(input int i);
        return (5 + (pen(i) ? 1 : 0)) * cpb(i);
    endfunction

    // line level at frame cycle k: start, d0..d2, optional even parity, stop
    function automatic logic exp_line(input int i, input logic [2:0] w, input int k);
        int b;
        b = k / cpb(i);
        if (b == 0) return 1'b0;
        if (b <= 3) return w[b-1];
        if (pen(i) && b == 4) return ^w;
        return 1'b1;
    endfunction

    task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s inst%0d t=%0t actual=%0h required=%0h", name, i, $time, act, exp);
        end
    endtask

    // model: position within the current frame, or -1 when idle
    always @(posedge mclk or posedge resetb) begin
        for (int i = 0; i < N; i++) begin
            if (resetb) begin
                pos[i] = -1;
                mready[i] = 1'b0;
            end else if (pos[i] >= 0) begin
                if (pos[i] == flen(i) - 1) begin
                    pos[i] = -1;
                    mready[i] = 1'b1;
                end else pos[i]++;
            end else if (mready[i] && tx_valid[i]) begin
                word[i] = tx_data[i];
                pos[i] = 0;
                mready[i] = 1'b0;
            end else mready[i] = 1'b1;
        end
    end

    always @(negedge mclk) begin
        if (go) begin
            for (int i = 0; i < N; i++) begin
                if (pos[i] >= 0) begin
                    chk("m_tx_ready", i, tx_ready[i], 0);
                    chk("m_haze", i, haze[i], 1);
                    chk("m_purple", i, purple[i], exp_line(i, word[i], pos[i]));
                    chk("m_electric", i, electric[i], pos[i] % cpb(i) == 0);
                    chk("m_ladyland", i, ladyland[i], pos[i] == flen(i) - 1);
                end else begin
                    chk("m_tx_ready", i, tx_ready[i], mready[i]);
                    chk("m_haze", i, haze[i], 0);
                    chk("m_purple", i, purple[i], 1);
                    chk("m_electric", i, electric[i], 0);
                    chk("m_ladyland", i, ladyland[i], 0);
                end
            end
        end
    end

    task automatic send(input int i, input logic [2:0] d, input logic [2:0] nd, input bit keep,
                        output logic [31:0] line, output logic [31:0] el, output logic [31:0] ld,
                        output int hz, output int n);
        tx_data[i] = d;
        tx_valid[i] = 1'b1;
        n = 0;
        do begin
            @(negedge mclk);
            n++;
        end while (!haze[i] && n < 12);
        chk("frame_start", i, haze[i], 1);
        tx_data[i] = nd;
        if (!keep) tx_valid[i] = 1'b0;
        line = '0;
        el = '0;
        ld = '0;
        hz = 0;
        while (haze[i] && hz < 32) begin
            line[hz] = purple[i];
            el[hz] = electric[i];
            ld[hz] = ladyland[i];
            hz++;
            @(negedge mclk);
        end
        chk("ready_back", i, tx_ready[i], 1);
        chk("idle_line", i, purple[i], 1);
    endtask

    task automatic frame(input int i, input logic [2:0] d, input logic [2:0] nd, input bit keep,
                         input logic [31:0] xl, input logic [31:0] xe, input logic [31:0] xd,
                         input int xh, input int xn);
        logic [31:0] line, el, ld;
        int hz, n;
        send(i, d, nd, keep, line, el, ld, hz, n);
        chk("lit_gap", i, n, xn);
        chk("lit_haze_len", i, hz, xh);
        chk("lit_line", i, line, xl);
        chk("lit_electric", i, el, xe);
        chk("lit_ladyland", i, ld, xd);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout t=%0t", $time);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            tx_valid[i] = 1'b0;
            tx_data[i] = '0;
        end
        #1 resetb = 1'b1;
        repeat (5) @(negedge mclk);
        go = 1;
        for (int i = 0; i < N; i++) begin
            chk("rst_tx_ready", i, tx_ready[i], 0);
            chk("rst_purple", i, purple[i], 1);
            chk("rst_haze", i, haze[i], 0);
            chk("rst_electric", i, electric[i], 0);
            chk("rst_ladyland", i, ladyland[i], 0);
        end
        resetb = 1'b0;
        @(negedge mclk);
        chk("release_ready", 0, tx_ready[0], 1);

        frame(0, 3'b101, 3'b101, 0, 32'hF0F0F0, 32'h111111, 32'h800000, 24, 1);
        frame(0, 3'b001, 3'b001, 0, 32'hFF00F0, 32'h111111, 32'h800000, 24, 1);
        frame(1, 3'b111, 3'b111, 0, 32'hFFFF0, 32'h11111, 32'h80000, 20, 1);

        // held valid: data changed mid-frame must not reach the first frame
        frame(0, 3'b011, 3'b110, 1, 32'hF00FF0, 32'h111111, 32'h800000, 24, 1);
        chk("b2b_idle_haze", 0, haze[0], 0);
        frame(0, 3'b110, 3'b110, 0, 32'hF0FF00, 32'h111111, 32'h800000, 24, 1);

        frame(2, 3'b010, 3'b010, 0, 32'h34, 32'h3F, 32'h20, 6, 1);

        // reset during the first cycle of data bit 1
        tx_data[0] = 3'b101;
        tx_valid[0] = 1'b1;
        @(negedge mclk);
        chk("pre_rst_haze", 0, haze[0], 1);
        tx_valid[0] = 1'b0;
        repeat (8) @(negedge mclk);
        chk("pre_rst_electric", 0, electric[0], 1);
        chk("pre_rst_purple", 0, purple[0], 0);
        #2 resetb = 1'b1;
        #1;
        chk("async_purple", 0, purple[0], 1);
        chk("async_haze", 0, haze[0], 0);
        chk("async_electric", 0, electric[0], 0);
        chk("async_ladyland", 0, ladyland[0], 0);
        chk("async_tx_ready", 0, tx_ready[0], 0);
        repeat (2) @(negedge mclk);
        resetb = 1'b0;
        @(negedge mclk);
        frame(0, 3'b101, 3'b101, 0, 32'hF0F0F0, 32'h111111, 32'h800000, 24, 1);

        repeat (3) @(negedge mclk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/voodoo_child.md
Name: voodoo_child

Overview:
- Serial frame transmitter for the purple/electric/haze guitarist link; the sending end of the link whose receiver consumes those three lines.
- Accepts a parallel word over a valid/ready handshake.
- Serialises the word as start bit, LSB-first data, optional even parity and stop bit, at a programmable bit period.
- Drives purple (line data), electric (bit strobe) and haze (frame envelope), plus a completion pulse.

Parameters:
WIDTH, 3, data bits per frame (>=1)
CLKS_PER_BIT, 4, mclk cycles per bit period (>=1)
PARITY_EN, 1, 1 = append even-parity bit after data; 0 = no parity bit

Ports:
mclk  input  1  single clock, all logic on rising edge
resetb  input  1  asynchronous, active-high reset (asserted = 1), released synchronously by the integrator
tx_data  input  WIDTH  word to send; sampled only on handshake
tx_valid  input  1  tx_data valid
tx_ready  output  1  block idle, word accepted when tx_valid & tx_ready at rising edge
purple  output  1  serial line; idles high
electric  output  1  one-cycle strobe on first cycle of every bit period in a frame
haze  output  1  high for whole frame, start bit through stop bit
ladyland  output  1  one-cycle pulse on last cycle of stop bit

Behaviour:
- Reset values: tx_ready=0, purple=1, electric=0, haze=0, ladyland=0; state IDLE; counters 0. All outputs registered.
- Reset mid-frame: outputs take reset values immediately (asynchronous); frame abandoned, no ladyland.
- First rising edge after release: tx_ready=1.
- States: IDLE -> START -> DATA -> (PARITY if PARITY_EN) -> STOP -> IDLE.
- IDLE:
  - tx_ready=1, purple=1, haze=0.
  - On tx_valid&tx_ready: capture tx_data into shift register, compute parity = XOR of captured bits.
  - Next cycle: tx_ready=0, state START.
- Bit timing:
  - Divider counts 0..CLKS_PER_BIT-1. Each bit is held for exactly CLKS_PER_BIT cycles.
  - electric=1 when divider==0 within a frame. CLKS_PER_BIT=1: electric stays high for the whole frame.
- START: purple=0.
- DATA: bit index 0..WIDTH-1, LSB first. Shift register shifts right at end of each bit period.
- PARITY: purple = parity (even: total ones in data+parity is even).
- STOP:
  - purple=1.
  - On its last cycle: ladyland=1; next cycle state IDLE, haze=0, tx_ready=1.
- Frame length: (2+WIDTH+PARITY_EN)*CLKS_PER_BIT cycles of haze. With defaults this is 24.
- Back-to-back: at least one IDLE cycle between frames. tx_valid held high gives a new frame starting 2 cycles after ladyland.
- tx_data/tx_valid changes while busy are ignored; the word is never re-sampled mid-frame.
- haze, electric and purple change only on mclk edges; no glitches at state boundaries.

Decomposition:
- Shared package voodoo_pkg:
  - state encoding constants (IDLE, START, DATA, PARITY, STOP);
  - frame-length function of WIDTH/CLKS_PER_BIT/PARITY_EN, reused by the matching receiver and benches.
- One sub-module: riff_tick.
  - Bit-period divider with enable/clear.
  - Outputs first-cycle (electric source) and last-cycle (advance) flags.
- FSM, shift register and parity stay in voodoo_child.

Test Plan:
- Reset behaviour: hold resetb=1 for 5 cycles -> tx_ready=0, purple=1, haze=0, electric=0, ladyland=0; first edge after release -> tx_ready=1.
- Defaults, send tx_data=3'b101 -> purple = 0,1,0,1,0,1, each held 4 cycles (parity 0), haze high 24 cycles, electric pulses at frame cycles 0,4,8,12,16,20, ladyland on cycle 23, tx_ready back next cycle.
- PARITY_EN=1, tx_data=3'b001 -> parity bit=1; PARITY_EN=0, tx_data=3'b111 -> no parity bit, haze high 20 cycles.
- tx_valid held high with 3'b011 then 3'b110 -> two complete frames, exactly one idle cycle (haze=0, purple=1) between them; changing tx_data mid-frame does not alter the first frame.
- Assert resetb during DATA bit 1 -> same cycle purple=1, haze=0, electric=0; no ladyland; a clean full frame follows after release.
- CLKS_PER_BIT=1, WIDTH=3, parity on, tx_data=3'b010 -> 6-cycle frame, line 0,0,1,0,1,1, electric high all 6 cycles.
